// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - GF(2^8) helpers and types shared by the AES round datapath
package aes_pkg;

  typedef logic [7:0] byte_t;
  // Packed column; index 0 is row 0 (A / P).
  typedef logic [3:0][7:0] column_t;

  localparam byte_t AES_POLY    = 8'h1B;
  localparam logic  MODE_MIX    = 1'b1;
  localparam logic  MODE_INVMIX = 1'b0;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic byte_t gf_mul2(input byte_t b);
    return xtime(b);
  endfunction

  function automatic byte_t gf_mul3(input byte_t b);
    return xtime(b) ^ b;
  endfunction

  function automatic byte_t gf_mul9(input byte_t b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic byte_t gf_mul11(input byte_t b);
    byte_t x2;
    x2 = xtime(b);
    return xtime(xtime(x2)) ^ x2 ^ b;
  endfunction

  function automatic byte_t gf_mul13(input byte_t b);
    byte_t x4;
    x4 = xtime(xtime(b));
    return xtime(x4) ^ x4 ^ b;
  endfunction

  function automatic byte_t gf_mul14(input byte_t b);
    byte_t x2;
    byte_t x4;
    x2 = xtime(b);
    x4 = xtime(x2);
    return xtime(x4) ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/mix_column_comb.sv
// rtl/mix_column_comb.sv - combinational MixColumns / InvMixColumns on one column
module mix_column_comb
  import aes_pkg::*;
(
  input  column_t col,
  input  logic    control,
  output column_t result
);

  // Row i uses the base coefficient row rotated right by i, so the byte at
  // row i gets the leading coefficient and the rest follow cyclically.
  always_comb begin
    result = '0;
    for (int i = 0; i < 4; i++) begin
      if (control == MODE_MIX) begin
        result[i] = gf_mul2(col[i])
                  ^ gf_mul3(col[(i + 1) % 4])
                  ^ col[(i + 2) % 4]
                  ^ col[(i + 3) % 4];
      end else begin
        result[i] = gf_mul14(col[i])
                  ^ gf_mul11(col[(i + 1) % 4])
                  ^ gf_mul13(col[(i + 2) % 4])
                  ^ gf_mul9(col[(i + 3) % 4]);
      end
    end
  end

endmodule

// File: rtl/sequential_mix_invmix.sv
// rtl/sequential_mix_invmix.sv - registered single-column AES (Inv)MixColumns
module sequential_mix_invmix
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [7:0] C,
  input  logic [7:0] D,
  input  logic       control,
  output logic [7:0] P,
  output logic [7:0] Q,
  output logic [7:0] R,
  output logic [7:0] S
);

  column_t col_in;
  column_t col_mixed;
  column_t col_q;

  assign col_in = {D, C, B, A};

  mix_column_comb u_mix (
    .col     (col_in),
    .control (control),
    .result  (col_mixed)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_q <= '0;
    end else begin
      col_q <= col_mixed;
    end
  end

  assign P = col_q[0];
  assign Q = col_q[1];
  assign R = col_q[2];
  assign S = col_q[3];

endmodule

// File: tb/tb_sequential_mix_invmix.sv
// tb/tb_sequential_mix_invmix.sv - scoreboard bench for sequential_mix_invmix
module tb_sequential_mix_invmix;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] A = '0, B = '0, C = '0, D = '0;
  logic       control = 1'b0;
  logic [7:0] P, Q, R, S;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  sequential_mix_invmix dut (
    .clk     (clk),
    .reset   (reset),
    .A       (A),
    .B       (B),
    .C       (C),
    .D       (D),
    .control (control),
    .P       (P),
    .Q       (Q),
    .R       (R),
    .S       (S)
  );

  always #5 clk = ~clk;

  // Textbook shift-and-add multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] aa;
    logic [7:0] acc;
    aa = {1'b0, a};
    acc = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) acc = acc ^ aa[7:0];
      aa = aa << 1;
      if (aa[8]) aa = aa ^ 9'h11B;
    end
    return acc;
  endfunction

  // Column packed as {row0,row1,row2,row3}; matrix rows are the base row rotated right.
  function automatic logic [31:0] ref_mix(input logic [31:0] col, input logic fwd);
    logic [7:0] base [4];
    logic [7:0] in_b [4];
    logic [7:0] out_b [4];
    if (fwd) begin
      base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
    end else begin
      base[0] = 8'h0E; base[1] = 8'h0B; base[2] = 8'h0D; base[3] = 8'h09;
    end
    for (int r = 0; r < 4; r++) in_b[r] = col[31 - 8*r -: 8];
    for (int r = 0; r < 4; r++) begin
      out_b[r] = 8'h00;
      for (int c = 0; c < 4; c++) out_b[r] = out_b[r] ^ gmul(base[(c - r + 4) % 4], in_b[c]);
    end
    return {out_b[0], out_b[1], out_b[2], out_b[3]};
  endfunction

  function automatic logic [31:0] out_col();
    return {P, Q, R, S};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Inputs change at the falling edge; the expected value is queued for the next rising edge.
  task automatic drive(input logic [31:0] col, input logic ctl, input logic [31:0] exp);
    @(negedge clk);
    {A, B, C, D} = col;
    control = ctl;
    sb.push_back(exp);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (!reset) begin
      check("reset_hold", out_col(), 32'h0);
    end else if (sb.size() > 0) begin
      check("scoreboard", out_col(), sb.pop_front());
    end
  end

  logic [31:0] vec_in  [6] = '{32'h876E46A6, 32'hDB135345, 32'hF20A225C,
                                32'hD4D4D4D5, 32'h01010101, 32'h80808080};
  logic [31:0] vec_out [6] = '{32'h473794ED, 32'h8E4DA1BC, 32'h9FDC589D,
                                32'hD5D5D7D6, 32'h01010101, 32'h80808080};

  initial begin
    logic [31:0] col;
    logic        ctl;
    int          wait_cycles;

    // Random inputs and clocks while reset is held.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      {A, B, C, D} = $urandom;
      control = $urandom_range(0, 1);
      #2 check("reset_async", out_col(), 32'h0);
    end

    // Release with the FIPS vector; first edge loads it, then the inverse follows back-to-back.
    @(negedge clk);
    reset = 1'b1;
    {A, B, C, D} = vec_in[0];
    control = 1'b1;
    sb.push_back(vec_out[0]);
    drive(vec_out[0], 1'b0, vec_in[0]);

    for (int v = 1; v < 6; v++) begin
      drive(vec_in[v], 1'b1, vec_out[v]);
      drive(vec_out[v], 1'b0, vec_in[v]);
    end
    drive(32'hFF000000, 1'b1, 32'hE5FFFF1A);
    drive(32'hE5FFFF1A, 1'b0, 32'hFF000000);

    // Random columns, random direction, with occasional mid-stream async reset.
    for (int i = 0; i < 10000; i++) begin
      col = $urandom;
      ctl = $urandom_range(0, 1);
      drive(col, ctl, ref_mix(col, ctl));
      if (i % 2500 == 1234) begin
        @(posedge clk);
        #3 reset = 1'b0;
        #1 check("reset_midrun", out_col(), 32'h0);
        @(negedge clk);
        reset = 1'b1;
      end
    end

    // Round trip through the DUT in both orders.
    for (int i = 0; i < 200; i++) begin
      col = $urandom;
      ctl = i[0];
      while (sb.size() > 0) @(negedge clk);
      @(negedge clk);
      {A, B, C, D} = col;
      control = ctl;
      @(negedge clk);
      {A, B, C, D} = out_col();
      control = ~ctl;
      @(negedge clk);
      check("roundtrip", out_col(), col);
    end

    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 20) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending %0d expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
